// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's RAM port, instruction-fetch port and load/store-buffer port.
// The arbiter uses the slave modport; the requesters and the RAM model use master.
interface mem_arbiter_if;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        go_work;
    logic        l_or_s;
    logic [2:0]  width;
    logic [31:0] address;
    logic [31:0] value_store;
    logic        received;
    logic        has_result;
    logic [31:0] value_load;
    logic        clear_all;

    modport slave (
        input  mem_din, io_buffer_full, if_req, if_addr, go_work, l_or_s, width,
               address, value_store, clear_all,
        output mem_dout, mem_a, mem_wr, if_done, if_data, received, has_result, value_load
    );

    modport master (
        output mem_din, io_buffer_full, if_req, if_addr, go_work, l_or_s, width,
               address, value_store, clear_all,
        input  mem_dout, mem_a, mem_wr, if_done, if_data, received, has_result, value_load
    );
endinterface

// File: rtl/mem_arbiter.sv
// Grants IF or LSB access to the byte-wide RAM/IO port and sequences 1/2/4-byte
// requests into per-byte RAM cycles, assembling reads little-endian.
module mem_arbiter #(
    parameter logic [31:0] IO_ADDR    = 32'h00030000,
    parameter int          STARVE_MAX = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    mem_arbiter_if.slave bus
);
    localparam int            SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;
    typedef enum logic       {OWN_IF, OWN_LSB}            owner_t;

    state_t         r_state;
    state_t         w_state_next;
    owner_t         r_owner;
    logic [SW-1:0]  r_starve;
    logic [1:0]     r_k;
    logic [1:0]     r_last;
    logic           r_issue;
    logic           r_pend;
    logic [1:0]     r_pidx;
    logic [31:0]    r_rdata;
    logic [23:0]    r_sdata;
    logic [31:0]    r_mem_a;
    logic [7:0]     r_mem_dout;
    logic           r_if_done;
    logic [31:0]    r_if_data;
    logic           r_received;
    logic           r_has_result;
    logic [31:0]    r_value_load;

    logic           w_grant_if;
    logic           w_grant_lsb;
    logic           w_stall;
    logic           w_rd_done;
    logic           w_wr_adv;
    logic [1:0]     w_lsb_last;
    logic [31:0]    w_rdata;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_grant_if   = 1'b0;
        w_grant_lsb  = 1'b0;
        w_rd_done    = 1'b0;
        w_wr_adv     = 1'b0;
        w_stall      = (r_mem_a == IO_ADDR) && bus.io_buffer_full;

        case (bus.width)
            3'd1:    w_lsb_last = 2'd0;
            3'd2:    w_lsb_last = 2'd1;
            default: w_lsb_last = 2'd3;
        endcase

        w_rdata = r_rdata;
        w_rdata[{r_pidx, 3'b000} +: 8] = bus.mem_din;

        case (r_state)
            ST_IDLE: begin
                if (!bus.clear_all) begin
                    // IF is forced in once LSB has won STARVE_MAX times in a row over it.
                    if (bus.go_work && !(bus.if_req && r_starve >= STARVE_LIM))
                        w_grant_lsb = 1'b1;
                    else if (bus.if_req)
                        w_grant_if = 1'b1;
                end
                if (w_grant_if || (w_grant_lsb && !bus.l_or_s))
                    w_state_next = ST_READ;
                else if (w_grant_lsb)
                    w_state_next = ST_WRITE;
            end
            ST_READ: begin
                if (bus.clear_all) begin
                    w_state_next = ST_IDLE;
                end else if (r_pend && r_pidx == r_last) begin
                    w_rd_done    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // Stores are already committed, so clear_all does not abort them.
                if (!w_stall) begin
                    w_wr_adv = 1'b1;
                    if (r_k == r_last)
                        w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_state <= ST_IDLE;
        else if (rdy_in)
            r_state <= w_state_next;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_owner      <= OWN_IF;
            r_starve     <= '0;
            r_k          <= '0;
            r_last       <= '0;
            r_issue      <= 1'b0;
            r_pend       <= 1'b0;
            r_pidx       <= '0;
            r_rdata      <= '0;
            r_sdata      <= '0;
            r_mem_a      <= '0;
            r_mem_dout   <= '0;
            r_if_done    <= 1'b0;
            r_if_data    <= '0;
            r_received   <= 1'b0;
            r_has_result <= 1'b0;
            r_value_load <= '0;
        end else if (rdy_in) begin
            r_if_done    <= 1'b0;
            r_received   <= 1'b0;
            r_has_result <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_if || w_grant_lsb) begin
                        r_owner    <= w_grant_lsb ? OWN_LSB : OWN_IF;
                        r_mem_a    <= w_grant_lsb ? bus.address : bus.if_addr;
                        r_last     <= w_grant_lsb ? w_lsb_last : 2'd3;
                        r_k        <= '0;
                        r_issue    <= 1'b1;
                        r_pend     <= 1'b0;
                        r_pidx     <= '0;
                        r_rdata    <= '0;
                        r_mem_dout <= bus.value_store[7:0];
                        r_sdata    <= bus.value_store[31:8];
                        r_received <= w_grant_lsb;
                        if (w_grant_if)
                            r_starve <= '0;
                        else if (bus.if_req)
                            r_starve <= r_starve + 1'b1;
                    end
                end
                ST_READ: begin
                    if (!bus.clear_all) begin
                        // mem_din carries the byte for the address driven one cycle earlier.
                        if (r_pend)
                            r_rdata <= w_rdata;
                        if (w_rd_done) begin
                            if (r_owner == OWN_LSB) begin
                                r_has_result <= 1'b1;
                                r_value_load <= w_rdata;
                            end else begin
                                r_if_done <= 1'b1;
                                r_if_data <= w_rdata;
                            end
                        end
                        r_pend <= r_issue;
                        r_pidx <= r_k;
                        if (r_issue && r_k != r_last) begin
                            r_k     <= r_k + 2'd1;
                            r_mem_a <= r_mem_a + 32'd1;
                        end else begin
                            r_issue <= 1'b0;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_wr_adv && r_k != r_last) begin
                        r_k        <= r_k + 2'd1;
                        r_mem_a    <= r_mem_a + 32'd1;
                        r_mem_dout <= r_sdata[7:0];
                        r_sdata    <= {8'h00, r_sdata[23:8]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Pulses held in their registers while rdy_in is low appear once it returns.
    assign bus.mem_a      = r_mem_a;
    assign bus.mem_dout   = r_mem_dout;
    assign bus.mem_wr     = (r_state == ST_WRITE) && rdy_in && !w_stall;
    assign bus.if_done    = r_if_done && rdy_in;
    assign bus.if_data    = r_if_data;
    assign bus.received   = r_received && rdy_in;
    assign bus.has_result = r_has_result && rdy_in;
    assign bus.value_load = r_value_load;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: stimulus queues expected completions,
// writes and acknowledgements with their cycle numbers; a negedge monitor checks them.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.IO_ADDR(32'h00030000), .STARVE_MAX(2)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t q_ifd[$];
    exp_t q_ldr[$];
    exp_t q_rcv[$];
    exp_t q_wr[$];

    // RAM model: preset bytes, otherwise a pattern derived from the address.
    logic [7:0] ram [logic [31:0]];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a))
            return ram[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        bus.mem_din <= ram_rd(bus.mem_a);
        if (bus.mem_wr)
            ram[bus.mem_a] = bus.mem_dout;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents an output event.
    exp_t e;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.if_done) begin
                if (q_ifd.size() == 0) check("unexpected if_done", 64'(bus.if_done), 64'd0);
                else begin
                    e = q_ifd.pop_front();
                    check("if_done cycle", 64'(cyc), 64'(e.cyc));
                    check("if_data", 64'(bus.if_data), 64'(e.data));
                end
            end
            if (bus.has_result) begin
                if (q_ldr.size() == 0) check("unexpected has_result", 64'(bus.has_result), 64'd0);
                else begin
                    e = q_ldr.pop_front();
                    check("has_result cycle", 64'(cyc), 64'(e.cyc));
                    check("value_load", 64'(bus.value_load), 64'(e.data));
                end
            end
            if (bus.received) begin
                if (q_rcv.size() == 0) check("unexpected received", 64'(bus.received), 64'd0);
                else begin
                    e = q_rcv.pop_front();
                    check("received cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (bus.mem_wr) begin
                if (q_wr.size() == 0) check("unexpected mem_wr", 64'(bus.mem_wr), 64'd0);
                else begin
                    e = q_wr.pop_front();
                    check("write cycle", 64'(cyc), 64'(e.cyc));
                    check("write addr", 64'(bus.mem_a), 64'(e.addr));
                    check("write byte", 64'(bus.mem_dout), 64'(e.data));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_push(input int kind, input int c, input logic [31:0] a, input logic [31:0] d);
        exp_t x;
        x = '{cyc: c, addr: a, data: d};
        case (kind)
            0: q_ifd.push_back(x);
            1: q_ldr.push_back(x);
            2: q_rcv.push_back(x);
            default: q_wr.push_back(x);
        endcase
    endtask

    task automatic lsb_req(input logic st, input logic [2:0] w, input logic [31:0] a, input logic [31:0] v);
        bus.go_work     = 1'b1;
        bus.l_or_s      = st;
        bus.width       = w;
        bus.address     = a;
        bus.value_store = v;
    endtask

    int c;

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.io_buffer_full = 1'b0;
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.go_work = 1'b0;
        bus.l_or_s = 1'b0;
        bus.width = 3'd0;
        bus.address = '0;
        bus.value_store = '0;
        bus.clear_all = 1'b0;
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        ram[32'h205] = 8'hAA; ram[32'h206] = 8'hBB;

        step(3);
        check("reset mem_a", 64'(bus.mem_a), 64'd0);
        check("reset mem_dout", 64'(bus.mem_dout), 64'd0);
        check("reset mem_wr", 64'(bus.mem_wr), 64'd0);
        check("reset if_done", 64'(bus.if_done), 64'd0);
        check("reset if_data", 64'(bus.if_data), 64'd0);
        check("reset received", 64'(bus.received), 64'd0);
        check("reset has_result", 64'(bus.has_result), 64'd0);
        check("reset value_load", 64'(bus.value_load), 64'd0);
        rst = 1'b0;
        step(1);

        // IF word read at 0x100
        c = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        exp_push(0, c + 6, 0, 32'h44332211);
        step(2);
        check("if read mem_a at T+2", 64'(bus.mem_a), 64'h101);
        step(4);
        bus.if_req = 1'b0;
        step(1);

        // LSB halfword load beats a simultaneous IF request; IF follows
        c = cyc;
        lsb_req(1'b0, 3'd2, 32'h205, 0);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        exp_push(2, c + 1, 0, 0);
        exp_push(1, c + 4, 0, 32'h0000BBAA);
        exp_push(0, c + 10, 0, 32'h44332211);
        step(1); bus.go_work = 1'b0;
        step(9); bus.if_req = 1'b0;
        step(1);

        // Word store to 0x40
        c = cyc;
        lsb_req(1'b1, 3'd4, 32'h40, 32'hDEADBEEF);
        exp_push(2, c + 1, 0, 0);
        exp_push(3, c + 1, 32'h40, 32'hEF);
        exp_push(3, c + 2, 32'h41, 32'hBE);
        exp_push(3, c + 3, 32'h42, 32'hAD);
        exp_push(3, c + 4, 32'h43, 32'hDE);
        step(1); bus.go_work = 1'b0;
        step(4);

        // Byte store to the IO address, stalled three cycles
        c = cyc;
        lsb_req(1'b1, 3'd1, 32'h00030000, 32'h41);
        exp_push(2, c + 1, 0, 0);
        exp_push(3, c + 4, 32'h00030000, 32'h41);
        step(1); bus.go_work = 1'b0; bus.io_buffer_full = 1'b1;
        step(3); bus.io_buffer_full = 1'b0;
        step(1);

        // clear_all aborts an IF read; a byte load captured at T+3 proves IDLE
        c = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        step(2); bus.clear_all = 1'b1; bus.if_req = 1'b0;
        step(1); bus.clear_all = 1'b0;
        lsb_req(1'b0, 3'd1, 32'h100, 0);
        exp_push(2, c + 4, 0, 0);
        exp_push(1, c + 6, 0, 32'h11);
        step(1); bus.go_work = 1'b0;
        step(3);

        // clear_all during a store is ignored
        c = cyc;
        lsb_req(1'b1, 3'd2, 32'h80, 32'h1234);
        exp_push(2, c + 1, 0, 0);
        exp_push(3, c + 1, 32'h80, 32'h34);
        exp_push(3, c + 2, 32'h81, 32'h12);
        step(1); bus.go_work = 1'b0;
        step(1); bus.clear_all = 1'b1;
        step(1); bus.clear_all = 1'b0;
        step(1);

        // Continuous LSB loads with IF pending: LSB, LSB, IF, LSB, LSB, IF
        c = cyc;
        lsb_req(1'b0, 3'd1, 32'h300, 0);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        exp_push(2, c + 1, 0, 0);  exp_push(1, c + 3, 0, 32'hA5);
        exp_push(2, c + 4, 0, 0);  exp_push(1, c + 6, 0, 32'hA5);
        exp_push(0, c + 12, 0, 32'h44332211);
        exp_push(2, c + 13, 0, 0); exp_push(1, c + 15, 0, 32'hA5);
        exp_push(2, c + 16, 0, 0); exp_push(1, c + 18, 0, 32'hA5);
        exp_push(0, c + 24, 0, 32'h44332211);
        step(24);
        bus.go_work = 1'b0; bus.if_req = 1'b0;
        step(1);

        // rdy_in low delays the has_result pulse
        c = cyc;
        lsb_req(1'b0, 3'd1, 32'h100, 0);
        exp_push(2, c + 1, 0, 0);
        exp_push(1, c + 5, 0, 32'h11);
        step(1); bus.go_work = 1'b0;
        step(2); rdy = 1'b0;
        check("mem_wr low while not ready", 64'(bus.mem_wr), 64'd0);
        step(2); rdy = 1'b1;
        step(2);

        // Halfword store wrapping past 0xFFFFFFFF
        c = cyc;
        lsb_req(1'b1, 3'd2, 32'hFFFFFFFF, 32'h5566);
        exp_push(2, c + 1, 0, 0);
        exp_push(3, c + 1, 32'hFFFFFFFF, 32'h66);
        exp_push(3, c + 2, 32'h00000000, 32'h55);
        step(1); bus.go_work = 1'b0;
        step(2);

        // width=3 is treated as a word
        c = cyc;
        lsb_req(1'b0, 3'd3, 32'h100, 0);
        exp_push(2, c + 1, 0, 0);
        exp_push(1, c + 6, 0, 32'h44332211);
        step(1); bus.go_work = 1'b0;
        step(6);

        for (int i = 0; i < 40; i++) begin
            if (q_ifd.size() + q_ldr.size() + q_rcv.size() + q_wr.size() == 0) break;
            step(1);
        end
        check("pending if_done", 64'(q_ifd.size()), 64'd0);
        check("pending has_result", 64'(q_ldr.size()), 64'd0);
        check("pending received", 64'(q_rcv.size()), 64'd0);
        check("pending writes", 64'(q_wr.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
